// File: rtl/common.sv
// rtl/common.sv - shared CBus request/response types and arbiter state encoding
//
// Contents:
//   cbus_size_t, cbus_len_t   beat size and burst length (len = beats - 1)
//   cbus_req_t                requester -> bus request
//   cbus_resp_t               bus -> requester response
//   cbus_arb_state_t          arbiter FSM states (IDLE, BUSY)
package common;

  typedef logic [2:0] cbus_size_t;
  typedef logic [3:0] cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    CBUS_ARB_IDLE,
    CBUS_ARB_BUSY
  } cbus_arb_state_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// rtl/cbus_arbiter_if.sv - CBus arbiter bus bundle (requester side and downstream side)
//
// Signals:
//   ireqs[NUM_REQ]   requests from the requesters
//   iresps[NUM_REQ]  responses routed back to the requesters
//   oreq             request forwarded to the AXI converter
//   oresp            response from the AXI converter
// Modports:
//   slave   arbiter view
//   master  requester + converter view (the environment around the arbiter)
interface cbus_arbiter_if
  import common::*;
#(
  parameter int NUM_REQ = 2
);

  cbus_req_t  ireqs  [NUM_REQ];
  cbus_resp_t iresps [NUM_REQ];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave  (input ireqs, output iresps, output oreq, input oresp);
  modport master (output ireqs, input iresps, input oreq, output oresp);

endinterface

// File: rtl/cbus_arb_pick.sv
// rtl/cbus_arb_pick.sv - combinational first-valid search starting at a given index
//
// Ports:
//   valid  in   NUM_REQ  request-valid vector
//   start  in   IDX_W    index searched first; search wraps modulo NUM_REQ
//   grant  out  IDX_W    first valid index found (0 when none)
//   found  out  1        at least one request is valid
module cbus_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   grant,
  output logic               found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to start so the nearest valid
  // index is the last assignment and therefore wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - grants the shared CBus master port one whole transaction at a time
//
// Ports:
//   clk     in   1      core clock, rising edge
//   resetn  in   1      asynchronous active-low reset
//   bus     slave       ireqs/iresps (requesters), oreq/oresp (AXI converter)
//   busy    out  1      a transaction is owned
//   owner   out  IDX_W  current owner, valid while busy
// Build option:
//   CBUS_ARB_RR_EN  defined: round-robin from last_owner+1; undefined: fixed
//                   priority, lowest index wins.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             resetn,
  cbus_arbiter_if.slave    bus,
  output logic             busy,
  output logic [IDX_W-1:0] owner
);

  cbus_arb_state_t    state;
  logic [NUM_REQ-1:0] req_valid;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   grant;
  logic               found;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = bus.ireqs[i].valid;
    end
  end

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] last_owner;

  assign start = (last_owner == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(last_owner + 1'b1);
`else
  assign start = '0;
`endif

  cbus_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .start (start),
    .grant (grant),
    .found (found)
  );

  // Completion always passes through IDLE, which gives the one-cycle
  // oreq.valid=0 bubble between transactions the converter depends on.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CBUS_ARB_IDLE;
      busy  <= 1'b0;
      owner <= '0;
`ifdef CBUS_ARB_RR_EN
      last_owner <= '0;
`endif
    end else begin
      case (state)
        CBUS_ARB_IDLE: begin
          if (found) begin
            state <= CBUS_ARB_BUSY;
            busy  <= 1'b1;
            owner <= grant;
`ifdef CBUS_ARB_RR_EN
            last_owner <= grant;
`endif
          end
        end
        CBUS_ARB_BUSY: begin
          // Owner dropping valid mid-burst is ignored; only last ends it.
          if (bus.oresp.ready && bus.oresp.last) begin
            state <= CBUS_ARB_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CBUS_ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // oreq depends only on state/owner/ireqs; oresp reaches iresps only.
  always_comb begin
    bus.oreq = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      bus.iresps[j] = '0;
    end
    if (state == CBUS_ARB_BUSY) begin
      bus.oreq          = bus.ireqs[owner];
      bus.iresps[owner] = bus.oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - scoreboard bench for cbus_arbiter (2 requesters)
module tb_cbus_arbiter;
  import common::*;

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } grant_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } resp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy;
  logic [0:0] owner;
  logic       busy_q = 1'b0;

  int tests = 0;
  int fails = 0;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];

  cbus_arbiter_if #(.NUM_REQ(2)) bus ();

  cbus_arbiter #(.NUM_REQ(2), .IDX_W(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] addr, input logic [3:0] len);
    bus.ireqs[idx].valid    = 1'b1;
    bus.ireqs[idx].is_write = 1'b0;
    bus.ireqs[idx].size     = 3'd2;
    bus.ireqs[idx].addr     = addr;
    bus.ireqs[idx].strobe   = 4'h0;
    bus.ireqs[idx].data     = 32'h0;
    bus.ireqs[idx].len      = len;
    bus.ireqs[idx].burst    = 2'b01;
  endtask

  task automatic push_grant(input int idx, input logic [31:0] addr);
    grant_t g;
    g.idx  = idx;
    g.addr = addr;
    exp_grant.push_back(g);
  endtask

  task automatic push_resp(input int idx, input logic [31:0] data, input logic last);
    resp_t r;
    r.idx  = idx;
    r.data = data;
    r.last = last;
    exp_resp.push_back(r);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  // Converter model: wait for a granted request, return beats base+b,
  // then the owner drops valid; optionally requester 1 raises at raise_beat.
  task automatic serve(input int idx, input int beats, input logic [31:0] base, input int raise_beat);
    int t;
    t = 0;
    while (bus.oreq.valid !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    check("serve_grant_seen", 64'(bus.oreq.valid), 64'd1);
    if (bus.oreq.valid !== 1'b1) return;
    for (int b = 0; b < beats; b++) begin
      if (b == raise_beat) begin
        set_req(1, 32'h2000_0000, 4'd0);
        push_grant(1, 32'h2000_0000);
      end
      push_resp(idx, base + 32'(b), (b == beats - 1));
      bus.oresp = '{ready: 1'b1, last: (b == beats - 1), data: base + 32'(b)};
      tick();
    end
    bus.oresp = '0;
    bus.ireqs[idx].valid = 1'b0;
    check("bubble_busy", 64'(busy), 64'd0);
    check("bubble_oreq_valid", 64'(bus.oreq.valid), 64'd0);
  endtask

  // Monitor: grant checked when busy rises, responses when any ready is seen.
  always @(negedge clk) begin
    grant_t g;
    resp_t  r;
    if (busy === 1'b1 && busy_q !== 1'b1) begin
      if (exp_grant.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got owner %0d expected no grant", owner);
      end else begin
        g = exp_grant.pop_front();
        check("grant_owner", 64'(owner), 64'(g.idx));
        check("grant_addr", 64'(bus.oreq.addr), 64'(g.addr));
        check("grant_valid", 64'(bus.oreq.valid), 64'd1);
      end
    end
    busy_q = busy;
    for (int j = 0; j < 2; j++) begin
      if (bus.iresps[j].ready === 1'b1) begin
        if (exp_resp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got req %0d data 0x%0h expected none", j, bus.iresps[j].data);
        end else begin
          r = exp_resp.pop_front();
          check("resp_idx", 64'(j), 64'(r.idx));
          check("resp_data", 64'(bus.iresps[j].data), 64'(r.data));
          check("resp_last", 64'(bus.iresps[j].last), 64'(r.last));
          check("resp_others_zero", 64'(bus.iresps[1-j] == '0), 64'd1);
        end
      end
    end
  end

  initial begin
    int          w;
    int          n0;
    int          n1;
    logic [31:0] a;

    bus.oresp    = '0;
    bus.ireqs[0] = '0;
    bus.ireqs[1] = '0;
    tick();
    tick();

    // reset values
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_oreq_zero", 64'(bus.oreq == '0), 64'd1);
    check("rst_iresp0_zero", 64'(bus.iresps[0]), 64'd0);
    check("rst_iresp1_zero", 64'(bus.iresps[1]), 64'd0);
    resetn = 1'b1;
    tick();

    // single read by requester 1
    set_req(1, 32'h1C00_0000, 4'd0);
    push_grant(1, 32'h1C00_0000);
    tick();
    check("single_latency_valid", 64'(bus.oreq.valid), 64'd1);
    serve(1, 1, 32'hDEAD_BEEF, -1);
    tick();

    // 16-beat burst by 0, requester 1 raises at beat 3 and waits
    set_req(0, 32'h0000_1000, 4'd15);
    push_grant(0, 32'h0000_1000);
    serve(0, 16, 32'h0000_B000, 2);
    serve(1, 1, 32'h0000_1111, -1);
    tick();

    // both requesters continuously back-to-back
    do_reset();
    n0 = 0;
    n1 = 0;
    set_req(0, 32'h5000_0000, 4'd1);
    set_req(1, 32'h6000_0000, 4'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef CBUS_ARB_RR_EN
      w = (k % 2 == 0) ? 1 : 0;
`else
      w = 0;
`endif
      a = (w == 0) ? 32'h5000_0000 + 32'(n0 * 256) : 32'h6000_0000 + 32'(n1 * 256);
      push_grant(w, a);
      serve(w, 2, 32'hA000_0000 + 32'(k * 16), -1);
      if (w == 0) n0++; else n1++;
      a = (w == 0) ? 32'h5000_0000 + 32'(n0 * 256) : 32'h6000_0000 + 32'(n1 * 256);
      set_req(w, a, 4'd1);
    end
    bus.ireqs[0] = '0;
    bus.ireqs[1] = '0;
    tick();
    check("simul_idle_after", 64'(busy), 64'd0);

    // reset at beat 5 of an 8-beat burst
    set_req(0, 32'h3000_0000, 4'd7);
    push_grant(0, 32'h3000_0000);
    tick();
    for (int b = 0; b < 4; b++) begin
      push_resp(0, 32'h0000_C000 + 32'(b), 1'b0);
      bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_C000 + 32'(b)};
      tick();
    end
    bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_C004};
    set_req(1, 32'h4000_0000, 4'd0);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_oreq_valid", 64'(bus.oreq.valid), 64'd0);
    check("rst_mid_iresp0", 64'(bus.iresps[0]), 64'd0);
    bus.oresp    = '0;
    bus.ireqs[0] = '0;
    tick();
    resetn = 1'b1;
    push_grant(1, 32'h4000_0000);
    serve(1, 1, 32'h0000_4444, -1);
    tick();

    // spurious ready in IDLE
    bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h55AA_55AA};
    tick();
    check("spur_busy", 64'(busy), 64'd0);
    check("spur_iresp0", 64'(bus.iresps[0]), 64'd0);
    check("spur_iresp1", 64'(bus.iresps[1]), 64'd0);
    tick();
    check("spur_busy_2", 64'(busy), 64'd0);
    bus.oresp = '0;
    tick();
    tick();

    check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    check("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    tests++;
    fails++;
    $display("FAIL global_timeout: got no end of run, expected finish before 50000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Shares the single cached-bus (CBus) master port in front of `CBusToAXI` between several requesters (instruction cache, data cache, uncached unit). It grants one whole transaction at a time and holds the grant until the last response beat. It forwards the winner's request downstream and routes responses back only to the winner. It sits inside the core top, between the requester CBus ports and the `oreq`/`oresp` pair that feeds the AXI converter.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..8; requester 0 is icache, 1 is dcache.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the owner index.

Ports:
- `clk`  in  1  core clock; everything is sampled on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireqs`  in  `cbus_req_t[NUM_REQ]`  requester requests. Fields: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `iresps`  out  `cbus_resp_t[NUM_REQ]`  per-requester responses. Fields: `ready`, `last`, `data`.
- `oreq`  out  `cbus_req_t`  request to the AXI converter.
- `oresp`  in  `cbus_resp_t`  response from the AXI converter.
- `busy`  out  1  a transaction is owned.
- `owner`  out  `IDX_W`  index of the current owner; valid only while `busy` is high.

## Operation
CBus protocol:
- A requester raises `valid` and holds all request fields stable until the beat where `ready && last` is seen.
- One beat completes on each cycle with `resp.ready` high.

The state machine has two states, IDLE and BUSY; reset state is IDLE.

IDLE:
- `oreq` is all-zero, in particular `oreq.valid` = 0.
- All `iresps` are zero.
- If any `ireqs[i].valid` is high, the arbiter picks a winner, latches it into `owner` and moves to BUSY on the next edge.
- With no valid requester it stays in IDLE.

BUSY:
- `oreq` = `ireqs[owner]`, combinational pass-through.
- `iresps[owner]` = `oresp`; every other `iresps[j]` is zero.
- The arbiter leaves BUSY only on a cycle where `oresp.ready && oresp.last`, and returns to IDLE.
- Requests that arrive during BUSY wait and are not dropped.

Boundary conditions:
- **Owner drops `valid` mid-transaction:** this is a protocol violation. The arbiter stays in BUSY, keeps forwarding (now with `valid` = 0) and waits for `last`. No spurious responses go to other requesters.
- **New request on the completion cycle:** requesters that raise `valid` on the same cycle the owner completes are evaluated in IDLE on the next cycle.
- **Response with no transaction:** `oresp.ready` asserted in IDLE is ignored.
- **Reset:** asserting `resetn` low forces IDLE immediately and asynchronously, even mid-transaction.

Reset values of outputs:
- `busy` = 0, `owner` = 0.
- `oreq` = 0.
- `iresps` = 0.

## Timing
- Arbitration latency is 1 cycle: a request first seen in IDLE at edge N appears on `oreq` in the cycle after edge N.
- The response path is zero latency (combinational from `oresp` to `iresps`).
- There is exactly one IDLE bubble cycle between consecutive transactions, with `oreq.valid` = 0 during it. `CBusToAXI` relies on this.
- `owner` is registered.
- `oreq` is combinational from `ireqs` and `owner` only; there is no combinational path from `oresp` to `oreq`.

## Configuration
Macro `CBUS_ARB_RR_EN`:
- **Defined:** round-robin arbitration. A registered pointer `last_owner` (reset 0) records the most recent winner. The search starts at `last_owner+1`, modulo `NUM_REQ`, and wraps around. `last_owner` updates on entry to BUSY.
- **Undefined:** fixed priority; the lowest index wins. There is no pointer register and requester 0 can starve the others.

## Structure
- `cbus_req_t`, `cbus_resp_t`, `cbus_len_t` and `cbus_size_t` live in the shared package `common`.
- The local state enum (IDLE, BUSY) is declared in `common` as `cbus_arb_state_t`.
- One sub-module, `cbus_arb_pick`: combinational, parameterized by `NUM_REQ`. Inputs are a request-valid vector and a start index; outputs are a grant index and a found flag. In fixed-priority mode the start index is tied to 0.

## Test plan
- **Single read:** reset, then requester 1 issues a read with `addr` 0x1C00_0000, `len` 0 (one beat). Expect `oreq.valid` the cycle after; `oresp` returns `ready`=1, `last`=1, `data` 0xDEADBEEF. Then `iresps[1].data` = 0xDEADBEEF, `iresps[0]` = 0, and `busy` drops on the next edge.
- **Burst hold:** requester 0 issues a 16-beat burst while requester 1 raises `valid` at beat 3. Requester 1 receives no responses. Ownership switches to 1 only after the beat-16 `last`, following one IDLE cycle.
- **Simultaneous requests, `CBUS_ARB_RR_EN` defined:** requesters 0 and 1 issue back-to-back transactions continuously. Expect grants in the order 1,0,1,0 after reset, since the pointer starts at 0 and the search begins at index 1.
- **Simultaneous requests, macro undefined:** same stimulus as the previous test. Requester 0 wins every arbitration.
- **Reset mid-burst:** drop `resetn` at beat 5 of 8. `oreq.valid` = 0 and `busy` = 0 with no clock edge. After reset is released, a pending requester is granted from IDLE.
- **Spurious `oresp.ready`:** assert it in IDLE. All `iresps` stay 0 and the state stays IDLE.
